// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the per-channel state encoding and the counter width rule used by every channel.
// Contents: state_t, cnt_width(), holds_pll_rst().

package pll_sup_pkg;

  // Per-channel supervisor states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    WAIT   = 3'd2,
    STABLE = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  // Bits needed to hold the values 0..max_val. A zero limit still needs
  // one bit so the counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

  // The PLL is held in reset whenever the channel is not actively
  // trying to lock or already locked.
  function automatic logic holds_pll_rst(input state_t s);
    return (s == IDLE) || (s == RST) || (s == FAIL);
  endfunction

endpackage

// File: rtl/pll_sup_chan.sv
// One PLL channel: lock-input synchroniser, reset/timeout/debounce counters and the supervisor FSM.
// Outputs are registered from the next state, so locked/pll_rst change on the same edge as the state.
// Ports: clk, rst_n, enable, clear, lock_in (async) in; pll_rst, locked, lol_sticky, fail out;
//        event_pulse out only when PLL_SUP_IRQ_EN is defined (lol_sticky set or FAIL entered this edge).

module pll_sup_chan
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES   = 3,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int MAX_RETRY     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic lock_in,
  output logic pll_rst,
  output logic locked,
  output logic lol_sticky,
  output logic fail
`ifdef PLL_SUP_IRQ_EN
  ,
  output logic event_pulse
`endif
);

  localparam int RW = cnt_width(RST_CYCLES);
  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int TW = cnt_width(LOCK_TIMEOUT);
  localparam int MW = cnt_width(MAX_RETRY);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [MW-1:0] RETRY_MAX = MW'(MAX_RETRY);

  // Lock input synchroniser; only its last stage is visible to the FSM.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  state_t          state, state_n;
  logic [RW-1:0]   rst_cnt, rst_cnt_n;
  logic [SW-1:0]   stab_cnt, stab_cnt_n;
  logic [TW-1:0]   to_cnt, to_cnt_n;
  logic [MW-1:0]   retry_cnt, retry_cnt_n;
  logic            lol_n, fail_n;
  logic            retry_evt;
  logic            lol_set;
  logic            fail_enter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    rst_cnt_n   = rst_cnt;
    stab_cnt_n  = stab_cnt;
    to_cnt_n    = to_cnt;
    retry_cnt_n = retry_cnt;
    lol_n       = lol_sticky;
    fail_n      = fail;
    retry_evt   = 1'b0;
    lol_set     = 1'b0;
    fail_enter  = 1'b0;

    if (!enable) begin
      // Disable wins over everything; sticky flags survive it.
      state_n     = IDLE;
      rst_cnt_n   = '0;
      stab_cnt_n  = '0;
      to_cnt_n    = '0;
      retry_cnt_n = '0;
    end else if (clear) begin
      // Clear restarts the channel and swallows any event of this cycle.
      state_n     = RST;
      rst_cnt_n   = '0;
      stab_cnt_n  = '0;
      to_cnt_n    = '0;
      retry_cnt_n = '0;
      lol_n       = 1'b0;
      fail_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n     = RST;
          rst_cnt_n   = '0;
          retry_cnt_n = '0;
        end

        RST: begin
          if (rst_cnt == RST_LAST) begin
            state_n    = WAIT;
            to_cnt_n   = '0;
            stab_cnt_n = '0;
          end else begin
            rst_cnt_n = rst_cnt + 1'b1;
          end
        end

        WAIT: begin
          if (to_cnt != TO_LAST) to_cnt_n = to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            retry_evt = 1'b1;
          end else if (lock_s) begin
            state_n    = STABLE;
            stab_cnt_n = '0;
          end
        end

        STABLE: begin
          if (to_cnt != TO_LAST) to_cnt_n = to_cnt + 1'b1;
          // A lock completing on the final timeout cycle still counts as locked.
          if (lock_s && (stab_cnt == STAB_MAX)) begin
            state_n     = LOCKED;
            retry_cnt_n = '0;
          end else if (to_cnt == TO_LAST) begin
            retry_evt = 1'b1;
          end else if (!lock_s) begin
            state_n    = WAIT;
            stab_cnt_n = '0;
          end else begin
            // Bounded by STAB_MAX: reaching it with lock_s high leaves STABLE.
            stab_cnt_n = stab_cnt + 1'b1;
          end
        end

        LOCKED: begin
          if (!lock_s) begin
            lol_n     = 1'b1;
            lol_set   = 1'b1;
            retry_evt = 1'b1;
          end
        end

        FAIL: begin
          state_n = FAIL;
        end

        default: begin
          state_n = IDLE;
        end
      endcase

      if (retry_evt) begin
        if (retry_cnt < RETRY_MAX) begin
          state_n     = RST;
          rst_cnt_n   = '0;
          retry_cnt_n = retry_cnt + 1'b1;
        end else begin
          state_n    = FAIL;
          fail_n     = 1'b1;
          fail_enter = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt    <= '0;
      stab_cnt   <= '0;
      to_cnt     <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      locked     <= 1'b0;
      lol_sticky <= 1'b0;
      fail       <= 1'b0;
    end else begin
      rst_cnt    <= rst_cnt_n;
      stab_cnt   <= stab_cnt_n;
      to_cnt     <= to_cnt_n;
      retry_cnt  <= retry_cnt_n;
      pll_rst    <= holds_pll_rst(state_n);
      locked     <= (state_n == LOCKED);
      lol_sticky <= lol_n;
      fail       <= fail_n;
    end
  end

`ifdef PLL_SUP_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_pulse <= 1'b0;
    end else begin
      event_pulse <= lol_set | fail_enter;
    end
  end
`else
  // Event strobes only feed the interrupt path.
  logic unused_evt;
  assign unused_evt = lol_set ^ fail_enter;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// Multi-channel PLL lock supervisor: per-channel reset drive, lock debounce, timeout/retry, sticky loss-of-lock.
// all_locked is the AND of locked, registered (one cycle behind locked).
// Ports: clk, rst_n, enable/clear/lock_in[NUM_CH] in; pll_rst/locked/lol_sticky/fail[NUM_CH], all_locked out.
// Optional macro PLL_SUP_IRQ_EN adds irq: one-cycle pulse the cycle after any channel sets lol_sticky or enters FAIL.

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int SYNC_STAGES   = 3,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] clear,
  input  logic [NUM_CH-1:0] lock_in,
  output logic [NUM_CH-1:0] pll_rst,
  output logic [NUM_CH-1:0] locked,
  output logic [NUM_CH-1:0] lol_sticky,
  output logic [NUM_CH-1:0] fail,
  output logic              all_locked
`ifdef PLL_SUP_IRQ_EN
  ,
  output logic              irq
`endif
);

`ifdef PLL_SUP_IRQ_EN
  logic [NUM_CH-1:0] chan_evt;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pll_sup_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .RST_CYCLES    (RST_CYCLES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .MAX_RETRY     (MAX_RETRY)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable[i]),
      .clear      (clear[i]),
      .lock_in    (lock_in[i]),
      .pll_rst    (pll_rst[i]),
      .locked     (locked[i]),
      .lol_sticky (lol_sticky[i]),
      .fail       (fail[i])
`ifdef PLL_SUP_IRQ_EN
      ,
      .event_pulse(chan_evt[i])
`endif
    );
  end

  // Registered so downstream reset gating never sees a combinational glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= &locked;
    end
  end

`ifdef PLL_SUP_IRQ_EN
  // Simultaneous channel events merge into a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |chan_evt;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios followed by randomised lock/enable/clear traffic.
// A behavioural model predicts the outputs at each clock edge; a monitor compares at the falling edge.
// Ports driven: clk, rst_n, enable, clear, lock_in; irq checked when PLL_SUP_IRQ_EN is defined.

module tb_pll_lock_supervisor;

  localparam int NC   = 2;
  localparam int SYNC = 3;
  localparam int RSTC = 4;
  localparam int STAB = 8;
  localparam int TMO  = 64;
  localparam int MAXR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NC-1:0] enable = '0;
  logic [NC-1:0] clear = '0;
  logic [NC-1:0] lock_in = '0;
  logic [NC-1:0] pll_rst, locked, lol_sticky, fail;
  logic          all_locked;
  logic          irq_bit;
`ifdef PLL_SUP_IRQ_EN
  logic          irq;
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_CH        (NC),
    .SYNC_STAGES   (SYNC),
    .RST_CYCLES    (RSTC),
    .STABLE_CYCLES (STAB),
    .LOCK_TIMEOUT  (TMO),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .lock_in    (lock_in),
    .pll_rst    (pll_rst),
    .locked     (locked),
    .lol_sticky (lol_sticky),
    .fail       (fail),
    .all_locked (all_locked)
`ifdef PLL_SUP_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  typedef struct packed {
    logic [NC-1:0] pll_rst;
    logic [NC-1:0] locked;
    logic [NC-1:0] lol;
    logic [NC-1:0] fail;
    logic          all_locked;
    logic          irq;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- behavioural model ----------------
  // A channel is idle, resetting its PLL, hunting for lock (waiting or
  // debouncing, one phase here), locked, or failed.
  typedef enum int {M_IDLE, M_RESETTING, M_HUNT, M_LOCKED, M_FAILED} mphase_t;

  mphase_t ph       [NC];
  int      rst_left [NC];
  int      t_hunt   [NC];
  int      run      [NC];
  int      retries  [NC];
  bit      m_lol    [NC];
  bit      m_fail   [NC];
  bit      hist     [NC][SYNC];   // past lock_in samples, [0] newest
  bit      m_all, m_irq, evt_prev;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      ph[c] = M_IDLE; rst_left[c] = 0; t_hunt[c] = 0; run[c] = 0;
      retries[c] = 0; m_lol[c] = 0; m_fail[c] = 0;
      for (int k = 0; k < SYNC; k++) hist[c][k] = 0;
    end
    m_all = 0; m_irq = 0; evt_prev = 0;
  endfunction

  function automatic void model_edge();
    bit all_before, any_evt, ls, retry;
    if (!rst_n) begin
      model_reset();
      return;
    end
    all_before = 1;
    for (int c = 0; c < NC; c++) if (ph[c] != M_LOCKED) all_before = 0;
    any_evt = 0;
    for (int c = 0; c < NC; c++) begin
      ls    = hist[c][SYNC-1];
      retry = 0;
      if (!enable[c]) begin
        ph[c] = M_IDLE; retries[c] = 0;
      end else if (clear[c]) begin
        m_lol[c] = 0; m_fail[c] = 0; retries[c] = 0;
        ph[c] = M_RESETTING; rst_left[c] = RSTC;
      end else begin
        case (ph[c])
          M_IDLE: begin
            ph[c] = M_RESETTING; rst_left[c] = RSTC; retries[c] = 0;
          end
          M_RESETTING: begin
            rst_left[c]--;
            if (rst_left[c] == 0) begin
              ph[c] = M_HUNT; t_hunt[c] = 0; run[c] = 0;
            end
          end
          M_HUNT: begin
            t_hunt[c]++;
            run[c] = ls ? run[c] + 1 : 0;
            // Lock is declared SYNC+STAB+1 edges after the first high sample;
            // SYNC-1 of those edges fill the synchroniser, so the declaring
            // edge ends the (STAB+2)th consecutive synced-high cycle.
            if (run[c] == STAB + 2) begin
              ph[c] = M_LOCKED; retries[c] = 0;
            end else if (t_hunt[c] == TMO) begin
              retry = 1;
            end
          end
          M_LOCKED: begin
            if (!ls) begin
              m_lol[c] = 1; any_evt = 1; retry = 1;
            end
          end
          default: ;
        endcase
        if (retry) begin
          if (retries[c] < MAXR) begin
            retries[c]++; ph[c] = M_RESETTING; rst_left[c] = RSTC;
          end else begin
            ph[c] = M_FAILED; m_fail[c] = 1; any_evt = 1;
          end
        end
      end
      for (int k = SYNC - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = lock_in[c];
    end
    m_all    = all_before;
    m_irq    = evt_prev;
    evt_prev = any_evt;
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o = '0;
    for (int c = 0; c < NC; c++) begin
      o.pll_rst[c] = (ph[c] == M_IDLE) || (ph[c] == M_RESETTING) || (ph[c] == M_FAILED);
      o.locked[c]  = (ph[c] == M_LOCKED);
      o.lol[c]     = m_lol[c];
      o.fail[c]    = m_fail[c];
    end
    o.all_locked = m_all;
`ifdef PLL_SUP_IRQ_EN
    o.irq = m_irq;
`endif
    return o;
  endfunction

  // ---------------- comparison ----------------
  function automatic obs_t dut_obs();
    obs_t a;
    a = {pll_rst, locked, lol_sticky, fail, all_locked, irq_bit};
    return a;
  endfunction

  task automatic compare(input string name, input obs_t a, input obs_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got pll_rst=%b locked=%b lol=%b fail=%b all=%b irq=%b, want pll_rst=%b locked=%b lol=%b fail=%b all=%b irq=%b",
               name, a.pll_rst, a.locked, a.lol, a.fail, a.all_locked, a.irq,
               e.pll_rst, e.locked, e.lol, e.fail, e.all_locked, e.irq);
    end
  endtask

  // Monitor: outputs are valid every cycle; check each predicted cycle.
  int   mon_n = 0;
  obs_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        compare($sformatf("cycle_%0d", mon_n), dut_obs(), mon_e);
        mon_n++;
      end
    end
  end

  // One clock: the model consumes the inputs seen at this edge, then the
  // caller may change inputs just after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(cur_obs());
    #1;
  endtask

  // ---------------- stimulus ----------------
  int hold[NC];
  int guard;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2 compare("reset_state", dut_obs(), cur_obs());
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Normal lock: raise lock_in one cycle after pll_rst falls.
    enable = 2'b11;
    guard = 0;
    while ((ph[0] != M_HUNT || ph[1] != M_HUNT) && guard < 40) begin tick(); guard++; end
    tick();
    lock_in = 2'b11;
    repeat (30) tick();

    // Debounce on channel 0: 5 high, 2 low, then high.
    clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    lock_in[0] = 1'b0;
    guard = 0;
    while (ph[0] != M_HUNT && guard < 40) begin tick(); guard++; end
    lock_in[0] = 1'b1; repeat (5) tick();
    lock_in[0] = 1'b0; repeat (2) tick();
    lock_in[0] = 1'b1; repeat (30) tick();

    // Loss of lock on channel 1 only.
    lock_in[1] = 1'b0; repeat (10) tick();
    lock_in[1] = 1'b1; repeat (30) tick();

    // Timeout and retries exhausted on channel 0.
    lock_in[0] = 1'b0;
    repeat (3 * (RSTC + TMO) + 20) tick();

    // Clear out of FAIL with lock present, then disable mid-debounce.
    lock_in[0] = 1'b1;
    clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    guard = 0;
    while (!(ph[0] == M_HUNT && run[0] >= 4) && guard < 40) begin tick(); guard++; end
    enable[0] = 1'b0; repeat (3) tick();
    enable[0] = 1'b1; repeat (30) tick();

    // Randomised traffic: long lock runs, short glitches, rare disable/clear.
    for (int c = 0; c < NC; c++) hold[c] = 0;
    for (int n = 0; n < 2500; n++) begin
      for (int c = 0; c < NC; c++) begin
        if (hold[c] == 0) begin
          lock_in[c] = ~lock_in[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(5, 120));
        end else begin
          hold[c]--;
        end
        if (enable[c]) begin
          if ($urandom_range(0, 299) == 0) enable[c] = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          enable[c] = 1'b1;
        end
        clear[c] = ($urandom_range(0, 399) == 0);
      end
      tick();
    end

    // Async reset while both channels are locked.
    enable = 2'b11; lock_in = 2'b11; clear = 2'b11; tick(); clear = 2'b00;
    guard = 0;
    while ((ph[0] != M_LOCKED || ph[1] != M_LOCKED) && guard < 200) begin tick(); guard++; end
    repeat (3) tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare("async_reset", dut_obs(), cur_obs());
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked cycles, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
